tdm_demux_8_1: RTL and testbench

Time-division demultiplexer that splits one serial TDM stream into eight parallel channels. It is the receive-end counterpart of the 8:1 channel multiplexer. It locks onto a frame-sync marker, steps a 3-bit slot counter on each valid sample, and presents all eight channels together, registered, once per complete frame. A flywheel tolerates isolated sync misses and drops lock after repeated misses.

---
 rtl/tdm_demux_8_1.sv | 155 +++++++++++++++
 tb/tb_tdm_demux_8_1.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_8_1.sv
// ============================================================================
// Module   : tdm_demux_8_1
// Purpose  : 8-channel TDM receiver. It locks to the frame sync and presents
//            all slots together, registered, once per complete frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux_8_1 #(
  parameter int WIDTH      = 1,
  parameter int MISS_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [2:0]       s,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int C_MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [C_MISS_W-1:0] C_MISS_LIM = MISS_LIMIT[C_MISS_W-1:0];

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                r_state;
  logic [2:0]            r_slot;
  logic [C_MISS_W-1:0]   r_miss;
  logic [WIDTH-1:0]      r_shadow [7];
  logic [WIDTH-1:0]      r_out    [8];
  logic                  r_frame_valid;
  logic                  r_sync_err;

  state_t                w_state_nxt;
  logic [2:0]            w_slot_nxt;
  logic [C_MISS_W-1:0]   w_miss_nxt;
  logic [C_MISS_W-1:0]   w_miss_inc;
  logic                  w_wr_en;
  logic [2:0]            w_wr_idx;
  logic                  w_frame_done;
  logic                  w_sync_err;

  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_miss_nxt   = r_miss;
    w_miss_inc   = r_miss + 1'b1;
    w_wr_en      = 1'b0;
    w_wr_idx     = 3'd0;
    w_frame_done = 1'b0;
    w_sync_err   = 1'b0;

    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (fsync) begin
            w_wr_en     = 1'b1;
            w_slot_nxt  = 3'd1;
            w_miss_nxt  = '0;
            w_state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (r_slot == 3'd0) begin
            if (fsync) begin
              w_wr_en    = 1'b1;
              w_slot_nxt = 3'd1;
              w_miss_nxt = '0;
            end else if (w_miss_inc == C_MISS_LIM) begin
              // Final tolerated miss: drop the sample and start hunting again.
              w_sync_err  = 1'b1;
              w_state_nxt = HUNT;
              w_slot_nxt  = 3'd0;
              w_miss_nxt  = '0;
            end else begin
              w_sync_err = 1'b1;
              w_wr_en    = 1'b1;
              w_slot_nxt = 3'd1;
              w_miss_nxt = w_miss_inc;
            end
          end else if (fsync) begin
            // Early sync wins over frame completion, even at slot 7.
            w_sync_err = 1'b1;
            w_wr_en    = 1'b1;
            w_slot_nxt = 3'd1;
            w_miss_nxt = '0;
          end else if (r_slot == 3'd7) begin
            w_frame_done = 1'b1;
            w_slot_nxt   = 3'd0;
          end else begin
            w_wr_en    = 1'b1;
            w_wr_idx   = r_slot;
            w_slot_nxt = r_slot + 3'd1;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_slot        <= 3'd0;
      r_miss        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      for (int k = 0; k < 7; k++) r_shadow[k] <= '0;
      for (int k = 0; k < 8; k++) r_out[k]    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_miss        <= w_miss_nxt;
      r_frame_valid <= w_frame_done;
      r_sync_err    <= w_sync_err;
      for (int k = 0; k < 7; k++) begin
        if (w_wr_en && (w_wr_idx == 3'(k))) r_shadow[k] <= din;
      end
      if (w_frame_done) begin
        for (int k = 0; k < 7; k++) r_out[k] <= r_shadow[k];
        r_out[7] <= din;
      end
    end
  end

  assign o0          = r_out[0];
  assign o1          = r_out[1];
  assign o2          = r_out[2];
  assign o3          = r_out[3];
  assign o4          = r_out[4];
  assign o5          = r_out[5];
  assign o6          = r_out[6];
  assign o7          = r_out[7];
  assign s           = r_slot;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = (r_state == LOCK);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_8_1.sv
// ============================================================================
// Module   : tb_tdm_demux_8_1
// Purpose  : Directed self-checking bench for tdm_demux_8_1 (WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_8_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din;
  logic       din_valid;
  logic       fsync;
  logic [0:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [2:0] s;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic [7:0] w_obus;

  int n_checks = 0;
  int n_pass   = 0;

  tdm_demux_8_1 #(.WIDTH(1), .MISS_LIMIT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .fsync      (fsync),
    .o0         (o0),
    .o1         (o1),
    .o2         (o2),
    .o3         (o3),
    .o4         (o4),
    .o5         (o5),
    .o6         (o6),
    .o7         (o7),
    .s          (s),
    .frame_valid(frame_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Channel 0 in the MSB so hex constants read in slot order.
  assign w_obus = {o0, o1, o2, o3, o4, o5, o6, o7};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else
      n_pass++;
  endtask

  task automatic step(input logic d, input logic f, input logic v);
    @(negedge clk);
    din       = d;
    fsync     = f;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Sends the low n bits of 'bits', most significant first, no fsync.
  task automatic send_seq(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) step(bits[n-1-i], 1'b0, 1'b1);
  endtask

  // Full frame, slot 0 first; optional idle gap after each of slots 0..6.
  task automatic send_frame(input logic [7:0] bits, input logic sync0, input int gap);
    for (int i = 0; i < 8; i++) begin
      step(bits[7-i], sync0 && (i == 0), 1'b1);
      if (gap > 0 && i < 7) begin
        for (int g = 0; g < gap; g++) step(1'b1, 1'b1, 1'b0);
        check("gap_s_hold", 32'(s), 32'(i + 1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; fsync = 1'b0;
    #2;
    check("rst_obus", 32'(w_obus), 32'h00);
    check("rst_s", 32'(s), 0);
    check("rst_fv", 32'(frame_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_serr", 32'(sync_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // No fsync: stay hunting.
    send_seq(8'h07, 3);
    check("hunt_locked", 32'(locked), 0);
    check("hunt_s", 32'(s), 0);

    // Basic frame 1,0,1,1,0,0,1,0.
    step(1'b1, 1'b1, 1'b1);
    check("lock_rise", 32'(locked), 1);
    check("lock_s1", 32'(s), 1);
    send_seq(8'h59, 6);
    check("pre7_s", 32'(s), 7);
    check("pre7_fv", 32'(frame_valid), 0);
    step(1'b0, 1'b0, 1'b1);
    check("basic_obus", 32'(w_obus), 32'hB2);
    check("basic_fv", 32'(frame_valid), 1);
    check("basic_s", 32'(s), 0);
    check("basic_locked", 32'(locked), 1);
    check("basic_serr", 32'(sync_err), 0);
    step(1'b0, 1'b0, 1'b0);
    check("fv_one_cycle", 32'(frame_valid), 0);
    check("obus_hold", 32'(w_obus), 32'hB2);

    // Gapped frame, 3 idle cycles between samples.
    send_frame(8'h4D, 1'b1, 3);
    check("gap_obus", 32'(w_obus), 32'h4D);
    check("gap_fv", 32'(frame_valid), 1);
    step(1'b0, 1'b0, 1'b0);
    check("gap_fv_drop", 32'(frame_valid), 0);

    // Early sync at slot 5.
    step(1'b1, 1'b1, 1'b1);
    send_seq(8'h0F, 4);
    check("early_pre_s", 32'(s), 5);
    step(1'b0, 1'b1, 1'b1);
    check("early_serr", 32'(sync_err), 1);
    check("early_fv", 32'(frame_valid), 0);
    check("early_obus", 32'(w_obus), 32'h4D);
    check("early_s", 32'(s), 1);
    step(1'b1, 1'b0, 1'b1);
    check("early_serr_drop", 32'(sync_err), 0);
    send_seq(8'h03, 6);
    check("early_frame_obus", 32'(w_obus), 32'h43);
    check("early_frame_fv", 32'(frame_valid), 1);

    // Back-to-back frames: fresh fsync right after slot 7.
    send_frame(8'hF0, 1'b1, 0);
    check("b2b_obus_a", 32'(w_obus), 32'hF0);
    check("b2b_fv_a", 32'(frame_valid), 1);
    step(1'b1, 1'b1, 1'b1);
    check("b2b_fv_next", 32'(frame_valid), 0);
    check("b2b_serr", 32'(sync_err), 0);
    check("b2b_s", 32'(s), 1);
    send_seq(8'h2A, 7);
    check("b2b_obus_b", 32'(w_obus), 32'hAA);
    check("b2b_fv_b", 32'(frame_valid), 1);

    // Flywheel: miss 1 and 2 are tolerated, miss 3 drops lock.
    step(1'b0, 1'b0, 1'b1);
    check("miss1_serr", 32'(sync_err), 1);
    check("miss1_locked", 32'(locked), 1);
    check("miss1_s", 32'(s), 1);
    send_seq(8'h01, 7);
    check("miss1_obus", 32'(w_obus), 32'h01);
    check("miss1_fv", 32'(frame_valid), 1);
    check("miss1_serr_clr", 32'(sync_err), 0);
    step(1'b1, 1'b0, 1'b1);
    check("miss2_serr", 32'(sync_err), 1);
    send_seq(8'h4C, 7);
    check("miss2_obus", 32'(w_obus), 32'hCC);
    check("miss2_locked", 32'(locked), 1);
    step(1'b1, 1'b0, 1'b1);
    check("miss3_serr", 32'(sync_err), 1);
    check("miss3_locked", 32'(locked), 0);
    check("miss3_s", 32'(s), 0);
    step(1'b1, 1'b0, 1'b1);
    check("hunt2_locked", 32'(locked), 0);
    check("hunt2_serr", 32'(sync_err), 0);
    check("hunt2_obus", 32'(w_obus), 32'hCC);
    step(1'b1, 1'b1, 1'b0);
    check("fsync_novalid", 32'(locked), 0);
    step(1'b1, 1'b1, 1'b1);
    check("relock", 32'(locked), 1);
    check("relock_s", 32'(s), 1);

    // Asynchronous reset mid-frame.
    send_seq(8'h00, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_obus", 32'(w_obus), 32'h00);
    check("midrst_s", 32'(s), 0);
    check("midrst_locked", 32'(locked), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    check("postrst_locked", 32'(locked), 0);
    check("postrst_s", 32'(s), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
